// File: rtl/seg_scan_if.sv
// seg_scan_if: load handshake and display-scan bundle for seg_scan_ctrl.
//   in_valid/in_value/in_ready : binary load request and acceptance
//   busy/ovf                   : conversion status and clamp flag
//   dec_bcd/dec_blank          : digit and blank presented to the shared decoder
//   digit_sel_n                : active-low digit select (bit 0 = units)
// master modport is the load source / display consumer; slave is the controller.
interface seg_scan_if;
  logic        in_valid;
  logic [13:0] in_value;
  logic        in_ready;
  logic        busy;
  logic        ovf;
  logic [3:0]  dec_bcd;
  logic        dec_blank;
  logic [3:0]  digit_sel_n;

  modport master (
    output in_valid, in_value,
    input  in_ready, busy, ovf, dec_bcd, dec_blank, digit_sel_n
  );

  modport slave (
    input  in_valid, in_value,
    output in_ready, busy, ovf, dec_bcd, dec_blank, digit_sel_n
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: accepts a binary value (clamped to 9999), converts it to four
// BCD digits with a 14-step shift-add-3 engine, and time-multiplexes the digits
// onto one shared BCD-to-7-segment decoder.
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : seg_scan_if.slave (load handshake, status, decoder/select outputs)
// Parameter REFRESH_DIV (>= 2): cycles each digit is held selected.
// Optional feature macro SEG_LZ_BLANK_EN: leading-zero blanking on dec_blank.
//
// state  | meaning
// IDLE   | ready for a load
// CONV   | one double-dabble iteration per clock, 14 in total
// COMMIT | copy BCD accumulator into the display registers
module seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input logic      clk,
  input logic      rst,
  seg_scan_if.slave bus
);

  localparam int PW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        accept, conv_step, commit;

  logic [13:0] bin_sh;
  logic [15:0] bcd_acc;
  logic [11:0] adj_lo;
  logic [3:0]  iter_cnt;
  logic [15:0] disp;
  logic        ovf_q;

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [1:0]    idx_next;
  logic          wrap;
  logic [3:0]    sel_q;
  logic [3:0]    bcd_q;
  logic          blank_q;
  logic [3:0]    nib_next;
  logic          blank_next;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    conv_step  = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        conv_step = 1'b1;
        if (iter_cnt == 4'd0) state_next = COMMIT;
      end
      COMMIT: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.ovf      = ovf_q;

  // ---------------- conversion datapath ----------------
  // Only the lower three nibbles need the +3 correction: with inputs <= 9999
  // the thousands nibble is at most 4 before every shift.
  always_comb begin
    adj_lo = bcd_acc[11:0];
    for (int k = 0; k < 3; k++) begin
      if (bcd_acc[4*k +: 4] >= 4'd5) adj_lo[4*k +: 4] = bcd_acc[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sh   <= '0;
      bcd_acc  <= '0;
      iter_cnt <= '0;
      disp     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        bin_sh   <= (bus.in_value > 14'd9999) ? 14'd9999 : bus.in_value;
        ovf_q    <= (bus.in_value > 14'd9999);
        bcd_acc  <= '0;
        iter_cnt <= 4'd13;
      end
      if (conv_step) begin
        bcd_acc <= {bcd_acc[14:12], adj_lo, bin_sh[13]};
        bin_sh  <= {bin_sh[12:0], 1'b0};
        if (iter_cnt != 4'd0) iter_cnt <= iter_cnt - 4'd1;
      end
      if (commit) disp <= bcd_acc;
    end
  end

  // ---------------- scanner ----------------
  assign wrap     = (presc == PW'(REFRESH_DIV - 1));
  assign idx_next = idx + 2'd1;

  always_comb begin
    case (idx_next)
      2'd0:    nib_next = disp[3:0];
      2'd1:    nib_next = disp[7:4];
      2'd2:    nib_next = disp[11:8];
      default: nib_next = disp[15:12];
    endcase
  end

`ifdef SEG_LZ_BLANK_EN
  // A digit is a leading zero when it and every more significant digit is zero.
  always_comb begin
    case (idx_next)
      2'd1:    blank_next = (disp[15:4] == 12'd0);
      2'd2:    blank_next = (disp[15:8] == 8'd0);
      2'd3:    blank_next = (disp[15:12] == 4'd0);
      default: blank_next = 1'b0;
    endcase
  end
`else
  assign blank_next = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      idx     <= 2'd0;
      sel_q   <= 4'b1110;
      bcd_q   <= 4'd0;
      blank_q <= 1'b0;
    end else if (wrap) begin
      presc   <= '0;
      idx     <= idx_next;
      sel_q   <= ~(4'b0001 << idx_next);
      bcd_q   <= nib_next;
      blank_q <= blank_next;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign bus.digit_sel_n = sel_q;
  assign bus.dec_bcd     = bcd_q;
  assign bus.dec_blank   = blank_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
  localparam int RD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  seg_scan_if sif ();

  seg_scan_ctrl #(.REFRESH_DIV(RD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: decimal value on display, cycles since reset release
  int   n;
  int   conv_left;
  int   disp_m;
  int   pend_m;
  bit   ovf_m;
  logic [3:0] exp_sel;
  logic [3:0] exp_bcd;
  logic       exp_blank;

  function automatic int p10(input int i);
    case (i)
      0: return 1;
      1: return 10;
      2: return 100;
      default: return 1000;
    endcase
  endfunction

  function automatic bit blank_of(input int d, input int i);
`ifdef SEG_LZ_BLANK_EN
    return (i > 0) && (d < p10(i));
`else
    return (d < 0) && (i < 0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".in_ready"},    32'(sif.in_ready),    32'(conv_left == 0));
    chk({tag, ".busy"},        32'(sif.busy),        32'(conv_left != 0));
    chk({tag, ".ovf"},         32'(sif.ovf),         32'(ovf_m));
    chk({tag, ".digit_sel_n"}, 32'(sif.digit_sel_n), 32'(exp_sel));
    chk({tag, ".dec_bcd"},     32'(sif.dec_bcd),     32'(exp_bcd));
    chk({tag, ".dec_blank"},   32'(sif.dec_blank),   32'(exp_blank));
  endtask

  task automatic model_reset();
    n = 0; conv_left = 0; disp_m = 0; pend_m = 0; ovf_m = 1'b0;
    exp_sel = 4'b1110; exp_bcd = 4'd0; exp_blank = 1'b0;
  endtask

  task automatic tick(input string tag);
    bit acc;
    int v;
    int idx;
    acc = (conv_left == 0) && (sif.in_valid === 1'b1);
    v   = int'(sif.in_value);
    @(posedge clk);
    n++;
    if (n % RD == 0) begin
      idx       = (n / RD) % 4;
      exp_sel   = ~(4'b0001 << idx);
      exp_bcd   = 4'((disp_m / p10(idx)) % 10);
      exp_blank = blank_of(disp_m, idx);
    end
    if (conv_left > 0) begin
      conv_left--;
      if (conv_left == 0) disp_m = pend_m;
    end
    if (acc) begin
      pend_m    = (v > 9999) ? 9999 : v;
      ovf_m     = (v > 9999);
      conv_left = 15;
    end
    #1;
    check_all(tag);
  endtask

  task automatic run(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) tick(tag);
  endtask

  task automatic load(input int v, input string tag);
    sif.in_valid = 1'b1;
    sif.in_value = 14'(v);
    tick(tag);
    sif.in_valid = 1'b0;
  endtask

  task automatic apply_reset(input string tag);
    sif.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all({tag, ".async"});
    repeat (3) @(posedge clk);
    #1;
    check_all({tag, ".held"});
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int v;
    int gap;
    sif.in_valid = 1'b0;
    sif.in_value = 14'd0;
    model_reset();

    // power-on reset and free-running rotation
    @(negedge clk);
    apply_reset("por");
    run(20, "rotate");

    // mid-frame reset
    run(2, "preframe");
    apply_reset("midframe");
    run(18, "rotate2");

    // basic load and clamp
    load(1234, "ld1234");
    run(15 + 4 * RD + 2, "conv1234");
    load(10000, "ld10000");
    run(15 + 4 * RD + 2, "conv10000");
    load(5, "ld5");
    run(15 + 4 * RD + 2, "conv5");

    // leading-zero patterns
    load(7, "ld7");
    run(15 + 4 * RD + 2, "conv7");
    load(0, "ld0");
    run(15 + 4 * RD + 2, "conv0");
    load(1005, "ld1005");
    run(15 + 4 * RD + 2, "conv1005");

    // request during conversion is ignored
    load(1111, "ld1111");
    run(3, "conv1111a");
    sif.in_valid = 1'b1;
    sif.in_value = 14'd4321;
    tick("ign4321");
    tick("ign4321");
    sif.in_valid = 1'b0;
    run(15 + 4 * RD, "conv1111b");

    // reset after the seventh iteration abandons the load
    load(2468, "ld2468");
    run(7, "iter7");
    apply_reset("rst_iter7");
    run(4 * RD + 2, "after_rst");

    // randomized loads, including held in_valid for back-to-back accepts
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(9990, 10010));
      else                           v = int'($urandom_range(0, 16383));
      sif.in_valid = 1'b1;
      sif.in_value = 14'(v);
      if ($urandom_range(0, 1) == 1) run(int'($urandom_range(1, 40)), "rnd_hold");
      else                           tick("rnd_load");
      sif.in_valid = 1'b0;
      gap = int'($urandom_range(0, 4 * RD + 16));
      run(gap, "rnd_gap");
    end
    run(16 + 4 * RD, "drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
